// File: rtl/mem_tester.sv
// Memory pattern tester: writes 2^ADDR_W 64-bit words as half-word pairs,
// reads them back, counts mismatches and streams each read word out.
module mem_tester #(
  parameter int ADDR_W  = 5,
  parameter int ERR_W   = 16,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [1:0]        mode,
  input  logic [63:0]       seed,
  output logic [19:0]       mem_addr,
  output logic              mem_write,
  output logic              mem_read,
  output logic [63:0]       mem_wrdata,
  input  logic              mem_ready,
  input  logic [31:0]       mem_rddata,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic              timeout_err,
  output logic [ERR_W-1:0]  err_count,
  output logic [ADDR_W-1:0] first_err_addr,
  output logic              res_valid,
  output logic [ADDR_W-1:0] res_addr,
  output logic [63:0]       res_data
);

  localparam int WC_W =
    (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  // Galois taps 64,63,61,60 on a right-shifting register
  localparam logic [63:0] TAPS = 64'hD800_0000_0000_0000;

  typedef enum logic [2:0] {
    IDLE, WR_REQ, WR_W1, WR_W2,
    RD_REQ, RD_W1, RD_W2, FIN
  } state_t;

  state_t state, state_nx;

  logic [ADDR_W-1:0] addr;
  logic [WC_W-1:0]   wcnt;
  logic [1:0]        mode_r;
  logic [63:0]       seed_r;
  logic [63:0]       lfsr;
  logic [31:0]       rd_hi;

  logic [ADDR_W-1:0] addr_inc;
  logic              last;
  logic              waiting;
  logic              tmo;
  logic              step;
  logic [63:0]       rep;
  logic [5:0]        sh;
  logic [63:0]       pat0;
  logic [63:0]       pat;
  logic [63:0]       rd_word;
  logic              mism;
  logic [63:0]       lfsr_nx;
  logic [63:0]       seed_ld;
  logic [63:0]       seed_lr;

  assign addr_inc = addr + ADDR_W'(1);
  assign last     = &addr;
  assign waiting  = (state == WR_W1) || (state == WR_W2) ||
                    (state == RD_W1) || (state == RD_W2);
  assign tmo      = waiting && !mem_ready &&
                    (wcnt == WC_W'(TIMEOUT));
  assign step     = mem_ready &&
                    ((state == WR_W2) || (state == RD_W2));
  assign sh       = 6'(addr);
  assign pat0     = seed_r ^ rep;
  assign rd_word  = {rd_hi, mem_rddata};
  assign mism     = (rd_word != pat);
  assign lfsr_nx  = lfsr[0] ? ((lfsr >> 1) ^ TAPS) : (lfsr >> 1);
  assign seed_ld  = (seed == '0) ? 64'h1 : seed;
  assign seed_lr  = (seed_r == '0) ? 64'h1 : seed_r;

  always_comb begin
    rep = '0;
    for (int i = 0; i < 64; i++) begin
      rep[i] = addr[i % ADDR_W];
    end
  end

  always_comb begin
    pat = pat0;
    unique case (mode_r)
      2'd0: pat = pat0;
      2'd1: pat = 64'h1 << sh;
      2'd2: pat = ~pat0;
      2'd3: pat = lfsr;
    endcase
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:   if (start) state_nx = WR_REQ;
      WR_REQ: state_nx = WR_W1;
      WR_W1:
        if (mem_ready) state_nx = WR_W2;
        else if (tmo) state_nx = FIN;
      WR_W2:
        if (mem_ready) state_nx = last ? RD_REQ : WR_REQ;
        else if (tmo) state_nx = FIN;
      RD_REQ: state_nx = RD_W1;
      RD_W1:
        if (mem_ready) state_nx = RD_W2;
        else if (tmo) state_nx = FIN;
      RD_W2:
        if (mem_ready) state_nx = last ? FIN : RD_REQ;
        else if (tmo) state_nx = FIN;
      FIN:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr           <= '0;
      wcnt           <= '0;
      mode_r         <= '0;
      seed_r         <= '0;
      lfsr           <= '0;
      rd_hi          <= '0;
      pass           <= 1'b0;
      timeout_err    <= 1'b0;
      err_count      <= '0;
      first_err_addr <= '0;
      res_valid      <= 1'b0;
      res_addr       <= '0;
      res_data       <= '0;
    end else begin
      res_valid <= 1'b0;
      if (waiting && !mem_ready && !tmo)
        wcnt <= wcnt + WC_W'(1);
      else
        wcnt <= '0;
      if (state == IDLE && start) begin
        mode_r         <= mode;
        seed_r         <= seed;
        err_count      <= '0;
        pass           <= 1'b0;
        timeout_err    <= 1'b0;
        first_err_addr <= '0;
        addr           <= '0;
        lfsr           <= seed_ld;
      end
      if (tmo) timeout_err <= 1'b1;
      if (state == RD_W1 && mem_ready) rd_hi <= mem_rddata;
      if (step) begin
        addr <= addr_inc;
        // read pass replays the sequence from the seed
        lfsr <= (state == WR_W2 && last) ? seed_lr : lfsr_nx;
      end
      if (state == RD_W2 && mem_ready) begin
        res_valid <= 1'b1;
        res_addr  <= addr;
        res_data  <= rd_word;
        if (mism) begin
          if (err_count != '1) err_count <= err_count + ERR_W'(1);
          if (err_count == '0) first_err_addr <= addr;
        end
      end
      if (state == FIN)
        pass <= (err_count == '0) && !timeout_err;
    end
  end

  assign mem_addr   = 20'(addr);
  assign mem_write  = (state == WR_REQ);
  assign mem_read   = (state == RD_REQ);
  assign mem_wrdata = mem_write ? pat : '0;
  assign busy       = (state != IDLE);
  assign done       = (state == FIN);

endmodule

// File: tb/tb_mem_tester.sv
// Bench for mem_tester: two-pulse memory responder, reference pattern
// model, directed and randomized runs on 5-bit and 7-bit instances.
module tb_mem_tester;

  localparam logic [63:0] POLY =
    (64'h1 << 63) | (64'h1 << 62) | (64'h1 << 60) | (64'h1 << 59);
  localparam logic [63:0] S0 = 64'h00070A57EDC0FFEE;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start_a = 1'b0;
  logic        start_b = 1'b0;
  logic [1:0]  mode = 2'd0;
  logic [63:0] seed = '0;
  logic        mem_ready = 1'b0;
  logic [31:0] mem_rddata = '0;
  logic        sel = 1'b0;
  logic        stall = 1'b0;

  logic [19:0] a_addr, b_addr;
  logic        a_wr, b_wr, a_rd, b_rd;
  logic [63:0] a_wd, b_wd;
  logic        a_busy, b_busy, a_done, b_done;
  logic        a_pass, b_pass, a_tmo, b_tmo;
  logic [15:0] a_err;
  logic [1:0]  b_err;
  logic [4:0]  a_ferr, a_ra;
  logic [6:0]  b_ferr, b_ra;
  logic        a_rv, b_rv;
  logic [63:0] a_rdat, b_rdat;

  mem_tester #(.ADDR_W(5), .ERR_W(16), .TIMEOUT(255)) u_a (
    .clk(clk), .rst_n(rst_n), .start(start_a), .mode(mode),
    .seed(seed), .mem_addr(a_addr), .mem_write(a_wr),
    .mem_read(a_rd), .mem_wrdata(a_wd), .mem_ready(mem_ready),
    .mem_rddata(mem_rddata), .busy(a_busy), .done(a_done),
    .pass(a_pass), .timeout_err(a_tmo), .err_count(a_err),
    .first_err_addr(a_ferr), .res_valid(a_rv),
    .res_addr(a_ra), .res_data(a_rdat)
  );

  mem_tester #(.ADDR_W(7), .ERR_W(2), .TIMEOUT(255)) u_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .mode(mode),
    .seed(seed), .mem_addr(b_addr), .mem_write(b_wr),
    .mem_read(b_rd), .mem_wrdata(b_wd), .mem_ready(mem_ready),
    .mem_rddata(mem_rddata), .busy(b_busy), .done(b_done),
    .pass(b_pass), .timeout_err(b_tmo), .err_count(b_err),
    .first_err_addr(b_ferr), .res_valid(b_rv),
    .res_addr(b_ra), .res_data(b_rdat)
  );

  wire [19:0] m_addr = sel ? b_addr : a_addr;
  wire        m_wr   = sel ? b_wr : a_wr;
  wire        m_rd   = sel ? b_rd : a_rd;
  wire [63:0] m_wd   = sel ? b_wd : a_wd;
  wire        m_busy = sel ? b_busy : a_busy;
  wire        m_done = sel ? b_done : a_done;
  wire        m_pass = sel ? b_pass : a_pass;
  wire        m_tmo  = sel ? b_tmo : a_tmo;
  wire [15:0] m_err  = sel ? 16'(b_err) : a_err;
  wire [19:0] m_ferr = sel ? 20'(b_ferr) : 20'(a_ferr);
  wire        m_rv   = sel ? b_rv : a_rv;
  wire [19:0] m_ra   = sel ? 20'(b_ra) : 20'(a_ra);
  wire [63:0] m_rdat = sel ? b_rdat : a_rdat;

  always #5 clk = ~clk;

  int ncmp = 0;
  int nfail = 0;
  int done_cnt = 0;
  int          wr_a[$];
  logic [63:0] wr_d[$];
  int          rd_a[$];
  int          res_a[$];
  logic [63:0] res_d[$];
  logic [63:0] mem  [int];
  logic [63:0] flip [int];

  function automatic logic [63:0] lfsr_n(
    input logic [63:0] s, input int n);
    logic [63:0] x;
    x = (s == '0) ? 64'h1 : s;
    for (int i = 0; i < n; i++)
      x = x[0] ? ((x >> 1) ^ POLY) : (x >> 1);
    return x;
  endfunction

  function automatic logic [63:0] model(
    input logic [1:0] m, input logic [63:0] s,
    input int a, input int aw);
    logic [63:0] r;
    for (int i = 0; i < 64; i++) r[i] = a[i % aw];
    case (m)
      2'd0:    return s ^ r;
      2'd1:    return 64'h1 << (a % 64);
      2'd2:    return ~(s ^ r);
      default: return lfsr_n(s, a);
    endcase
  endfunction

  task automatic chk(input string tag,
                     input logic [63:0] o, input logic [63:0] e);
    ncmp++;
    assert (o === e) else begin
      nfail++;
      $error("FAIL %s got %0h want %0h", tag, o, e);
    end
  endtask

  task automatic pulse(input logic [31:0] v);
    repeat ($urandom_range(0, 3)) begin
      @(posedge clk); #1;
    end
    mem_ready = 1'b1;
    mem_rddata = v;
    @(posedge clk); #1;
    mem_ready = 1'b0;
  endtask

  // two-pulse memory: high half first, then low half
  initial begin
    int ra;
    logic [63:0] rv;
    @(posedge clk); #1;
    forever begin
      if (m_wr === 1'b1) begin
        ra = int'(m_addr);
        wr_a.push_back(ra);
        wr_d.push_back(m_wd);
        mem[ra] = m_wd;
        @(posedge clk); #1;
        if (!stall) begin
          pulse(32'h0);
          pulse(32'h0);
        end
      end else if (m_rd === 1'b1) begin
        ra = int'(m_addr);
        rd_a.push_back(ra);
        rv = mem.exists(ra) ? mem[ra] : 64'h0;
        if (flip.exists(ra)) rv = rv ^ flip[ra];
        @(posedge clk); #1;
        pulse(rv[63:32]);
        pulse(rv[31:0]);
      end else begin
        @(posedge clk); #1;
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk); #1;
      if (m_done === 1'b1) done_cnt++;
      if (m_rv === 1'b1) begin
        res_a.push_back(int'(m_ra));
        res_d.push_back(m_rdat);
      end
    end
  end

  task automatic clear_logs();
    wr_a.delete(); wr_d.delete(); rd_a.delete();
    res_a.delete(); res_d.delete(); mem.delete();
    done_cnt = 0;
  endtask

  task automatic go(input bit which, input logic [1:0] m,
                    input logic [63:0] s);
    sel = which;
    @(posedge clk); #1;
    mode = m;
    seed = s;
    if (which) start_b = 1'b1;
    else       start_a = 1'b1;
    @(posedge clk); #1;
    start_a = 1'b0;
    start_b = 1'b0;
  endtask

  task automatic wait_done(input int maxc, output int cyc);
    cyc = 0;
    while (m_done !== 1'b1 && cyc < maxc) begin
      @(posedge clk); #1;
      cyc++;
    end
  endtask

  task automatic check_run(input string tag, input bit which,
                           input logic [1:0] m,
                           input logic [63:0] s,
                           input int aw, input int ew);
    int n, cyc, lim, bw, br, bres, ecnt, efirst, emax;
    logic [63:0] fm;
    n = 1 << aw;
    lim = 40 * n + 300;
    clear_logs();
    go(which, m, s);
    chk({tag, ".busy"}, 64'(m_busy), 64'(1));
    wait_done(lim, cyc);
    chk({tag, ".done_seen"}, 64'(cyc < lim), 64'(1));
    repeat (3) begin
      @(posedge clk); #1;
    end
    chk({tag, ".done_cnt"}, 64'(done_cnt), 64'(1));
    chk({tag, ".n_wr"}, 64'(wr_a.size()), 64'(n));
    chk({tag, ".n_rd"}, 64'(rd_a.size()), 64'(n));
    chk({tag, ".n_res"}, 64'(res_a.size()), 64'(n));
    bw = 0; br = 0; bres = 0;
    if (wr_a.size() == n && rd_a.size() == n &&
        res_a.size() == n) begin
      for (int i = 0; i < n; i++) begin
        fm = flip.exists(i) ? flip[i] : 64'h0;
        if (wr_a[i] != i || wr_d[i] !== model(m, s, i, aw)) bw++;
        if (rd_a[i] != i) br++;
        if (res_a[i] != i ||
            res_d[i] !== (model(m, s, i, aw) ^ fm)) bres++;
      end
    end
    chk({tag, ".wr_bad"}, 64'(bw), 64'(0));
    chk({tag, ".rd_bad"}, 64'(br), 64'(0));
    chk({tag, ".res_bad"}, 64'(bres), 64'(0));
    ecnt = flip.size();
    efirst = 0;
    if (ecnt > 0) void'(flip.first(efirst));
    emax = (1 << ew) - 1;
    chk({tag, ".err"}, 64'(m_err),
        64'((ecnt > emax) ? emax : ecnt));
    chk({tag, ".ferr"}, 64'(m_ferr), 64'(efirst));
    chk({tag, ".pass"}, 64'(m_pass), 64'(ecnt == 0));
    chk({tag, ".tmo"}, 64'(m_tmo), 64'(0));
    chk({tag, ".idle"}, 64'(m_busy), 64'(0));
  endtask

  initial begin
    int cyc;
    logic [1:0] rm;
    logic [63:0] rs, s3;

    repeat (3) @(posedge clk);
    #1;
    chk("rst.busy", 64'(a_busy), 64'(0));
    chk("rst.outs", {a_wr, a_rd, a_done, a_pass, a_tmo, a_rv},
        64'(0));
    chk("rst.err", 64'(a_err), 64'(0));
    chk("rst.addr", 64'(a_addr), 64'(0));
    chk("rst.res", a_rdat, 64'(0));
    rst_n = 1'b1;

    flip.delete();
    check_run("m0", 1'b0, 2'd0, S0, 5, 16);
    if (wr_d.size() == 32) begin
      chk("m0.addr0", wr_d[0], S0);
      chk("m0.addr31", wr_d[31], 64'hFFF8F5A8123F0011);
    end

    flip.delete();
    flip[7] = 64'h8;
    check_run("flip7", 1'b0, 2'd0, S0, 5, 16);
    if (res_d.size() == 32)
      chk("flip7.res", res_d[7], model(2'd0, S0, 7, 5) ^ 64'h8);

    for (int r = 0; r < 4; r++) begin
      flip.delete();
      rm = 2'($urandom_range(0, 3));
      rs = {$urandom, $urandom};
      repeat ($urandom_range(0, 3))
        flip[$urandom_range(0, 31)] =
          64'h1 << $urandom_range(0, 63);
      check_run($sformatf("rnd%0d", r), 1'b0, rm, rs, 5, 16);
    end

    flip.delete();
    check_run("lfsr0", 1'b0, 2'd3, 64'h0, 5, 16);
    if (wr_d.size() == 32 && res_d.size() == 32) begin
      chk("lfsr0.addr0", wr_d[0], 64'h1);
      cyc = 0;
      for (int i = 0; i < 32; i++)
        if (wr_d[i] !== res_d[i]) cyc++;
      chk("lfsr0.wr_eq_rd", 64'(cyc), 64'(0));
    end

    clear_logs();
    stall = 1'b1;
    go(1'b0, 2'd0, S0);
    wait_done(400, cyc);
    chk("tmo.latency", 64'(cyc), 64'(257));
    repeat (3) begin
      @(posedge clk); #1;
    end
    stall = 1'b0;
    chk("tmo.flag", 64'(a_tmo), 64'(1));
    chk("tmo.pass", 64'(a_pass), 64'(0));
    chk("tmo.no_read", 64'(rd_a.size()), 64'(0));
    chk("tmo.one_wr", 64'(wr_a.size()), 64'(1));
    chk("tmo.done_cnt", 64'(done_cnt), 64'(1));

    flip.delete();
    check_run("walk7", 1'b1, 2'd1, 64'h0, 7, 2);
    if (wr_d.size() == 128) begin
      chk("walk7.a5", wr_d[5], 64'h20);
      chk("walk7.a64", wr_d[64], 64'h1);
      chk("walk7.a127", wr_d[127], 64'h8000000000000000);
    end

    flip.delete();
    for (int i = 10; i < 128; i++) flip[i] = 64'h1 << (i % 64);
    check_run("sat7", 1'b1, 2'd0, {$urandom, $urandom}, 7, 2);

    flip.delete();
    clear_logs();
    go(1'b0, 2'd2, S0);
    cyc = 0;
    while (a_rd !== 1'b1 && cyc < 2000) begin
      @(posedge clk); #1;
      cyc++;
    end
    chk("mid.reach_rd", 64'(cyc < 2000), 64'(1));
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    chk("mid.busy", 64'(a_busy), 64'(0));
    chk("mid.outs", {a_wr, a_rd, a_done, a_pass, a_tmo, a_rv},
        64'(0));
    chk("mid.addr", 64'(a_addr), 64'(0));
    chk("mid.wd", a_wd, 64'(0));
    chk("mid.err", 64'({a_err, a_ferr, a_ra}), 64'(0));
    chk("mid.res", a_rdat, 64'(0));
    repeat (15) @(posedge clk);
    #1;
    chk("mid.no_done", 64'(done_cnt), 64'(0));
    rst_n = 1'b1;

    clear_logs();
    s3 = {$urandom, $urandom};
    go(1'b0, 2'd2, s3);
    repeat (20) @(posedge clk);
    #1;
    mode = 2'd1;
    seed = ~s3;
    start_a = 1'b1;
    @(posedge clk); #1;
    start_a = 1'b0;
    wait_done(3000, cyc);
    chk("re.done_seen", 64'(cyc < 3000), 64'(1));
    repeat (60) @(posedge clk);
    #1;
    chk("re.one_done", 64'(done_cnt), 64'(1));
    chk("re.idle", 64'(a_busy), 64'(0));
    chk("re.pass", 64'(a_pass), 64'(1));
    chk("re.n_wr", 64'(wr_a.size()), 64'(32));
    if (wr_a.size() == 32) begin
      chk("re.first_addr", 64'(wr_a[0]), 64'(0));
      cyc = 0;
      for (int i = 0; i < 32; i++)
        if (wr_d[i] !== model(2'd2, s3, i, 5)) cyc++;
      chk("re.wr_bad", 64'(cyc), 64'(0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             ncmp, nfail);
    $finish;
  end

endmodule

// File: doc/mem_tester.md
MEM_TESTER -- requirements
Module: mem_tester

Interface
Parameters (name, default, meaning):
REQ-001 The block SHALL provide ADDR_W, 5, number of tested address bits; words tested = 2^ADDR_W, legal range 1..20.
REQ-002 The block SHALL provide ERR_W, 16, width of the error counter.
REQ-003 The block SHALL provide TIMEOUT, 255, maximum cycles to wait for each mem_ready pulse.

Ports (name, direction, width, meaning):
REQ-004 The clock and reset SHALL be a single clock, clk (in, 1), and reset rst_n (in, 1), which is asynchronous and active-low.
REQ-005 start (in, 1) SHALL be a single-cycle pulse that begins a test run.
REQ-006 mode (in, 2) SHALL select the pattern: 0 seed-XOR-address, 1 walking one, 2 inverted mode 0, 3 LFSR.
REQ-007 seed (in, 64) SHALL be the pattern seed.
REQ-008 mem_addr (out, 20) SHALL be the word address, which is the address counter zero-extended.
REQ-009 mem_write and mem_read (out, 1 each) SHALL be request pulses.
REQ-010 mem_wrdata (out, 64) SHALL be the write word.
REQ-011 mem_ready (in, 1) SHALL be the controller half-word strobe.
REQ-012 mem_rddata (in, 32) SHALL be the read half-word.
REQ-013 busy (out, 1) SHALL be high while a run is in progress.
REQ-014 done (out, 1) SHALL pulse for one cycle at the end of a run.
REQ-015 pass (out, 1) SHALL indicate that the last run completed with no errors and no timeout.
REQ-016 timeout_err (out, 1) SHALL indicate that the last run aborted on a timeout.
REQ-017 err_count (out, ERR_W) SHALL give the number of mismatching words.
REQ-018 first_err_addr (out, ADDR_W) SHALL give the address of the first mismatching word.
REQ-019 res_valid (out, 1), res_addr (out, ADDR_W) and res_data (out, 64) SHALL form the per-word read-back stream.

Function
REQ-020 The state machine SHALL have the states IDLE, WR_REQ, WR_W1, WR_W2, RD_REQ, RD_W1, RD_W2 and FIN.
REQ-021 In IDLE, a start pulse SHALL latch mode and seed, clear err_count, pass, timeout_err and first_err_addr, zero the address counter, and move the state to WR_REQ.
REQ-022 A start pulse in any state other than IDLE SHALL be ignored, and changes to mode or seed during a run SHALL have no effect.
REQ-023 WR_REQ SHALL assert mem_write for exactly one cycle with mem_wrdata equal to pattern(addr), then move to WR_W1.
REQ-024 WR_W1 SHALL advance to WR_W2 on mem_ready.
REQ-025 WR_W2 SHALL, on mem_ready, increment the address; if the address wraps to 0 it SHALL move to RD_REQ, otherwise to WR_REQ.
REQ-026 RD_REQ SHALL assert mem_read for exactly one cycle, then move to RD_W1.
REQ-027 RD_W1 SHALL, on mem_ready, capture mem_rddata as bits 63:32 of the read word.
REQ-028 RD_W2 SHALL, on mem_ready, capture mem_rddata as bits 31:0, compare the assembled word against pattern(addr), and increment the address.
REQ-029 After RD_W2, if the address wraps to 0 the state SHALL move to FIN, otherwise to RD_REQ.
REQ-030 In mode 0, pattern(a) SHALL equal seed XOR the low 64 bits of a replicated ceil(64/ADDR_W) times.
REQ-031 In mode 1, pattern(a) SHALL equal 64'h1 shifted left by a mod 64.
REQ-032 In mode 2, pattern(a) SHALL equal the bitwise inverse of the mode 0 pattern.
REQ-033 In mode 3, pattern SHALL be a 64-bit Galois LFSR with taps 64, 63, 61 and 60, loaded with seed at entry to WR_REQ for address 0 and at entry to RD_REQ for address 0, and stepped once per completed word.
REQ-034 In mode 3, a seed of 0 SHALL be replaced by 64'h1.
REQ-035 On a mismatch, err_count SHALL increment and saturate at all ones.
REQ-036 On the first mismatch of a run, first_err_addr SHALL capture the address.
REQ-037 res_valid SHALL pulse for one cycle, one cycle after each RD_W2 completion, with res_addr and res_data holding the address and read word.
REQ-038 In every W1/W2 state, a wait counter SHALL count cycles without mem_ready and SHALL clear on each mem_ready.
REQ-039 When the wait counter reaches TIMEOUT, the block SHALL set timeout_err and go to FIN without issuing further requests.
REQ-040 FIN SHALL pulse done for one cycle, set pass = (err_count == 0) AND NOT timeout_err, and return to IDLE.
REQ-041 busy SHALL be high in every state except IDLE.
REQ-042 mem_ready outside the W1/W2 states SHALL be ignored.
REQ-043 mem_ready arriving in the same cycle as a timeout SHALL be taken as a valid ready, with no timeout raised.
REQ-044 pass, timeout_err, err_count and first_err_addr SHALL hold their values until the next accepted start.

Reset
REQ-045 While rst_n is low, the block SHALL immediately enter IDLE.
REQ-046 While rst_n is low, all outputs, the address counter, the wait counter and the LFSR SHALL be 0.
REQ-047 A reset asserted mid-run SHALL abandon the run with no done pulse.
REQ-048 The first start after rst_n deasserts SHALL behave identically to a start after power-up.

Verification
REQ-049 Scenario: ideal two-pulse memory model, ADDR_W=5, mode 0, seed 64'h00070A57EDC0FFEE -> 32 writes then 32 reads; addr 0 written with the seed; addr 31 written with 64'hFFF8F5A8123F0011; done pulses once; pass=1; err_count=0.
REQ-050 Scenario: as REQ-049, with the model flipping bit 3 of the read at addr 7 -> err_count=1, first_err_addr=7, pass=0, and one res_valid with res_addr=7 carrying the flipped data.
REQ-051 Scenario: model never asserts mem_ready after the first write -> done pulses 257 cycles after WR_REQ; timeout_err=1; pass=0; mem_read never asserted.
REQ-052 Scenario: mode 1, ADDR_W=7 -> addr 5 written with 64'h20, addr 64 written with 64'h1, addr 127 written with 64'h8000000000000000; pass=1.
REQ-053 Scenario: mode 3, seed 0 -> the write and read sequences are identical, addr 0 is written with 64'h1, and pass=1.
REQ-054 Scenario: rst_n pulsed low during RD_W1, then a start pulse is also issued while busy in a second run -> all outputs are 0 asynchronously; the new run restarts at addr 0; the start issued while busy is ignored, giving exactly one done per accepted start.
